// File: rtl/rule90_pkg.sv
// ----------------------------------------------------------------------------
// rule90_pkg
// Shared definitions for the Rule 90 inverse engine: the default cell count,
// the default width of the generation-count input, and the controller states.
// ----------------------------------------------------------------------------
package rule90_pkg;

   localparam int N_DEFAULT  = 512;
   localparam int SW_DEFAULT = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rule90_inverse_if.sv
// ----------------------------------------------------------------------------
// rule90_inverse_if
// Request/result bundle of the Rule 90 inverse engine.
//   start  - request strobe, only honoured while the engine is idle
//   data   - Rule 90 state whose predecessor is wanted
//   steps  - number of backward generations
//   busy   - engine is computing
//   done   - one-cycle completion pulse
//   q      - predecessor result, held between completions
// master: requester side, slave: engine side.
// ----------------------------------------------------------------------------
interface rule90_inverse_if
   import rule90_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int SW = SW_DEFAULT
);

   logic          start;
   logic [N-1:0]  data;
   logic [SW-1:0] steps;
   logic          busy;
   logic          done;
   logic [N-1:0]  q;

   modport master (
      output start,
      output data,
      output steps,
      input  busy,
      input  done,
      input  q
   );

   modport slave (
      input  start,
      input  data,
      input  steps,
      output busy,
      output done,
      output q
   );

endinterface

// File: rtl/rule90_inverse.sv
// ----------------------------------------------------------------------------
// rule90_inverse
// Computes the unique predecessor of a zero-boundary Rule 90 state, repeated
// for a requested number of generations.
//   clk    - single clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - rule90_inverse_if slave port (start/data/steps in,
//            busy/done/q out)
//
// With next[i] = prev[i-1] ^ prev[i+1] and zero boundaries, the odd cells of
// prev form a chain starting from next[0] and walking upward, and the even
// cells form a chain starting from next[N-1] and walking downward. Each RUN
// cycle advances both chains by one cell, so a generation takes N/2 cycles.
// ----------------------------------------------------------------------------
module rule90_inverse
   import rule90_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int SW = SW_DEFAULT
)(
   input  logic            clk,
   input  logic            reset,
   rule90_inverse_if.slave bus
);

   // k counts cell pairs (0..N/2-1); 2k needs exactly one more bit, which for
   // an even N is also the width of a cell index.
   localparam int KW = $clog2(N / 2);
   localparam int IW = KW + 1;

   localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};
   localparam logic [KW-1:0] K_ONE   = KW'(1);
   localparam logic [KW-1:0] K_LAST  = KW'(N / 2 - 1);
   localparam logic [IW-1:0] I_ONE   = IW'(1);
   localparam logic [IW-1:0] I_TOP   = IW'(N - 1);
   localparam logic [SW-1:0] G_ZERO  = {SW{1'b0}};
   localparam logic [SW-1:0] G_ONE   = SW'(1);
   localparam logic [N-1:0]  V_ZERO  = {N{1'b0}};

   state_t        state;
   logic [N-1:0]  cur;
   logic [N-1:0]  w;
   logic [N-1:0]  w_next;
   logic [N-1:0]  result;
   logic [KW-1:0] k;
   logic [SW-1:0] gen;
   logic          busy_flag;
   logic          done_flag;

   logic [IW-1:0] k2;
   logic [IW-1:0] odd_idx;
   logic [IW-1:0] odd_prev;
   logic [IW-1:0] even_src;
   logic [IW-1:0] even_idx;
   logic [IW-1:0] even_prev;
   logic          odd_val;
   logic          even_val;

   assign bus.busy = busy_flag;
   assign bus.done = done_flag;
   assign bus.q    = result;

   // Resolve odd cell 2k+1 and even cell N-2-2k of the predecessor this cycle.
   always_comb begin
      k2        = {k, 1'b0};
      odd_idx   = k2 + I_ONE;
      odd_prev  = k2 - I_ONE;
      even_src  = I_TOP - k2;
      even_idx  = even_src - I_ONE;
      // Wraps to N-2k modulo 2^IW; only used when k >= 1, where it is in range.
      even_prev = even_src + I_ONE;
      if (k == K_ZERO) begin
         odd_val  = cur[0];
         even_val = cur[N-1];
      end else begin
         odd_val  = cur[k2] ^ w[odd_prev];
         even_val = cur[even_src] ^ w[even_prev];
      end
      w_next           = w;
      w_next[odd_idx]  = odd_val;
      w_next[even_idx] = even_val;
   end

   // Controller: request capture, per-cycle pair resolution, generation count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur       <= V_ZERO;
         w         <= V_ZERO;
         result    <= V_ZERO;
         k         <= K_ZERO;
         gen       <= G_ZERO;
         busy_flag <= 1'b0;
         done_flag <= 1'b0;
      end else begin
         done_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.steps != G_ZERO) begin
                     cur       <= bus.data;
                     gen       <= bus.steps;
                     k         <= K_ZERO;
                     busy_flag <= 1'b1;
                     state     <= RUN;
                  end else begin
                     // Zero generations: the input is its own answer.
                     result    <= bus.data;
                     done_flag <= 1'b1;
                  end
               end
            end
            RUN: begin
               w <= w_next;
               if (k == K_LAST) begin
                  cur <= w_next;
                  k   <= K_ZERO;
                  if (gen == G_ONE) begin
                     gen       <= G_ZERO;
                     result    <= w_next;
                     done_flag <= 1'b1;
                     busy_flag <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     gen <= gen - G_ONE;
                  end
               end else begin
                  k <= k + K_ONE;
               end
            end
            default: begin
               state     <= IDLE;
               busy_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rule90_inverse.sv
// ----------------------------------------------------------------------------
// tb_rule90_inverse
// Directed bench for rule90_inverse. Each request pushes its expectation to a
// scoreboard; on done the entry is popped and the result is checked by
// running the forward rule `steps` times and by known constants where given.
// A small N=8/SW=3 instance covers the maximum generation count.
// ----------------------------------------------------------------------------
module tb_rule90_inverse;
   import rule90_pkg::*;

   localparam int N  = 512;
   localparam int SW = 8;

   typedef struct {
      logic [N-1:0] data;
      int           steps;
      bit           has_exact;
      logic [N-1:0] exact;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   rule90_inverse_if #(.N(N), .SW(SW)) bus ();
   rule90_inverse_if #(.N(8), .SW(3))  sbus ();

   rule90_inverse #(.N(N), .SW(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   rule90_inverse #(.N(8), .SW(3)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   // Forward Rule 90 step with zero boundaries.
   function automatic logic [N-1:0] rule90_fwd(input logic [N-1:0] p);
      return (p << 1) ^ (p >> 1);
   endfunction

   function automatic logic [N-1:0] fwd_n(input logic [N-1:0] p, input int n);
      logic [N-1:0] v;
      v = p;
      for (int i = 0; i < n; i++) v = rule90_fwd(v);
      return v;
   endfunction

   function automatic logic [7:0] rule90_fwd8(input logic [7:0] p);
      return (p << 1) ^ (p >> 1);
   endfunction

   function automatic logic [N-1:0] rand512();
      logic [N-1:0] r;
      for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the request is sampled by the next rising edge.
   task automatic start_req(input logic [N-1:0] d, input int s, input bit has_exact,
                            input logic [N-1:0] ex);
      exp_t e;
      e.data      = d;
      e.steps     = s;
      e.has_exact = has_exact;
      e.exact     = ex;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.data  = d;
      bus.steps = s[SW-1:0];
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for done, optionally pulsing start mid-run, then scores.
   task automatic wait_done(input bit inject, input int budget);
      exp_t         e;
      int           c;
      bit           seen;
      logic [N-1:0] q_hold;
      e      = sb.pop_front();
      c      = 0;
      seen   = 1'b0;
      q_hold = bus.q;
      while (c <= budget) begin
         if (c == 0 && e.steps != 0) check("busy_in_run", bus.busy, 1);
         if (e.steps == 0) check("busy_low_zero_steps", bus.busy, 0);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (inject && (c == 40 || c == 300)) begin
            bus.start = 1'b1;
            bus.data  = ~e.data;
            bus.steps = 8'd1;
         end else begin
            bus.start = 1'b0;
         end
         if (inject && c == 400) check("q_held_mid_run", bus.q, q_hold);
         @(negedge clk);
         c++;
      end
      bus.start = 1'b0;
      check("done_seen", seen, 1);
      check("latency", c, e.steps * N / 2);
      check("busy_at_done", bus.busy, 0);
      check("fwd_of_q", fwd_n(bus.q, e.steps), e.data);
      if (e.has_exact) check("q_exact", bus.q, e.exact);
   endtask

   task automatic idle_tick();
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] r2;
      logic [N-1:0] odd_bits;
      logic [N-1:0] one;
      logic [7:0]   sq;
      exp_t         dropped;
      int           done_count;
      int           c;

      odd_bits = {256{2'b10}};
      one      = {{(N-1){1'b0}}, 1'b1};

      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.data   = '0;
      bus.steps  = '0;
      sbus.start = 1'b0;
      sbus.data  = 8'h00;
      sbus.steps = 3'd0;
      #1;
      check("reset_q", bus.q, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single impulse at cell 0: predecessor has every odd cell set.
      start_req(one, 1, 1'b1, odd_bits);
      wait_done(1'b0, 300);
      idle_tick();

      // Impulse at cell 1: predecessor is cell 0 alone.
      start_req(one << 1, 1, 1'b1, one);
      wait_done(1'b0, 300);
      idle_tick();

      // Zero generations: immediate pass-through, busy never rises.
      r = rand512();
      start_req(r, 0, 1'b1, r);
      wait_done(1'b0, 5);
      idle_tick();
      check("busy_idle_after_zero", bus.busy, 0);

      // Three generations with ignored mid-run start pulses.
      r = rand512();
      start_req(r, 3, 1'b0, '0);
      wait_done(1'b1, 900);
      idle_tick();

      // Reset mid-run: abort, no done, fresh run afterwards.
      r = rand512();
      start_req(r, 1, 1'b0, '0);
      repeat (99) @(negedge clk);
      reset = 1'b1;
      #1;
      dropped = sb.pop_back();
      check("abort_q", bus.q, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0;
      done_count = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_count++;
      end
      check("no_done_after_abort", done_count, 0);
      check("idle_after_abort", bus.busy, 0);
      r = rand512();
      start_req(r, 2, 1'b0, '0);
      wait_done(1'b0, 600);
      idle_tick();

      // Back-to-back: second request issued in the done cycle.
      r  = rand512();
      r2 = rand512();
      start_req(r, 1, 1'b0, '0);
      wait_done(1'b0, 300);
      start_req(r2, 2, 1'b0, '0);
      check("b2b_done_dropped", bus.done, 0);
      check("b2b_no_gap", bus.busy, 1);
      wait_done(1'b0, 600);
      idle_tick();

      // Maximum generation count on the small instance: 7 * 8/2 cycles.
      sbus.start = 1'b1;
      sbus.data  = 8'hB5;
      sbus.steps = 3'd7;
      @(negedge clk);
      sbus.start = 1'b0;
      c = 0;
      while (c < 100 && sbus.done !== 1'b1) begin
         @(negedge clk);
         c++;
      end
      check("small_latency", c, 28);
      sq = sbus.q;
      for (int i = 0; i < 7; i++) sq = rule90_fwd8(sq);
      check("small_fwd_of_q", sq, 8'hB5);
      check("small_busy_at_done", sbus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rule90_inverse.md
RULE90_INVERSE -- requirements
Module: rule90_inverse

Interface
REQ-001 Parameter N, default 512: cell count; SHALL be even and >= 4.
REQ-002 Parameter SW, default 8: width of the steps input.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 data  input  N  Rule 90 state whose predecessor is wanted; sampled with start.
REQ-007 steps  input  SW  number of backward generations; sampled with start.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse at completion.
REQ-010 q  output  N  predecessor result; held stable between completions.

Function
REQ-011 Forward rule (zero boundary) SHALL be next[i] = prev[i-1] XOR prev[i+1], with prev[-1] = prev[N] = 0; the block SHALL compute the unique prev for a given next.
REQ-012 FSM states SHALL be IDLE and RUN; reset SHALL enter IDLE.
REQ-013 IDLE + start + steps != 0: latch data into working register cur, latch steps into a generation counter, clear pair index k, enter RUN.
REQ-014 IDLE + start + steps == 0: q <= data, done pulse on the next edge, remain IDLE, busy never high.
REQ-015 RUN, each cycle k (0..N/2-1), two cells SHALL be resolved into work register w: odd cell 2k+1 = cur[0] for k=0, else cur[2k] XOR w[2k-1]; even cell N-2-2k = cur[N-1] for k=0, else cur[N-1-2k] XOR w[N-2k].
REQ-016 One generation SHALL take exactly N/2 cycles; at k = N/2-1 the resolved w SHALL become cur, k SHALL wrap to 0, and the generation counter SHALL decrement.
REQ-017 When the last generation completes: q <= final w, done = 1 for exactly one cycle, busy = 0, return to IDLE in the same edge.
REQ-018 Total latency SHALL be steps*N/2 cycles from the start-sampling edge to the edge that raises done.
REQ-019 busy SHALL be high exactly while in RUN.
REQ-020 start while in RUN SHALL be ignored, with no effect on cur, counters, or q.
REQ-021 start in the cycle done is high SHALL be accepted normally, because the FSM is then in IDLE.
REQ-022 q SHALL change only at completion edges and reset; it SHALL NOT show partial results.
REQ-023 steps at its maximum (2^SW - 1) SHALL run to completion without counter overflow.

Reset
REQ-024 Asserting reset SHALL immediately force the state to IDLE and clear q, busy, done, cur, w, k, and the generation counter to 0.
REQ-025 Reset during RUN SHALL abort the computation with no done pulse; the first start after release SHALL begin a fresh computation.

Structure
REQ-026 Package rule90_pkg SHALL hold the default N, SW, and the FSM state enum (IDLE, RUN).
REQ-027 No sub-module SHALL be required in RTL; a combinational forward-step model, rule90_fwd, SHALL live in the bench for self-checking.

Verification
REQ-028 N=512, data=512'h1, steps=1, start -> after 256 cycles done=1, q = 512'hAAAA...AAAA (all odd bits set).
REQ-029 N=512, data=512'h2, steps=1 -> after 256 cycles q = 512'h1.
REQ-030 data=random, steps=0 -> done one cycle after start, q=data, busy stays 0.
REQ-031 data=random, steps=3 -> done after 768 cycles; applying rule90_fwd three times to q SHALL equal data; start pulses sent mid-run SHALL be ignored.
REQ-032 Reset asserted at cycle 100 of a run -> q=0, busy=0, no done pulse; a new start then completes correctly.
REQ-033 Back-to-back test: start in the done cycle -> a second computation begins with no idle gap and produces a correct result.
